// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: big-endian words written from address 0.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              il_in_clk,
  input  logic              il_in_rst,
  input  logic              il_in_start,
  input  logic [7:0]        il_in_byte,
  input  logic              il_in_valid,
  output logic              il_out_ready,
  output logic [ADDR_W-1:0] il_out_addr,
  output logic [31:0]       il_out_data,
  output logic              il_out_wren,
  output logic              il_out_cpu_hold,
  output logic              il_out_busy,
  output logic              il_out_done,
  output logic              il_out_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] HDR_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              accept;
  logic [15:0]       hdr_n;
  logic [ADDR_W:0]   words_inc;
  logic              last_word;

  assign accept    = il_in_valid && il_out_ready;
  assign hdr_n     = {count_q[15:8], il_in_byte};
  assign words_inc = words_q + 1'b1;
  assign last_word = (32'(words_inc) == 32'(count_q));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (il_in_start) begin
          state_d    = HDR_HI;
          words_d    = '0;
          addr_d     = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d = {il_in_byte, 8'h00};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr_n;
          if (hdr_n == 16'd0 || {1'b0, hdr_n} > DEPTH_L) state_d = ERROR;
          else                                           state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          data_d     = {data_q[23:0], il_in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + il_in_byte;
`endif
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // The address may wrap after the final word; it is cleared before the next frame.
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = (il_in_byte == sum_q) ? DONE : ERROR;
`else
        state_d = ERROR;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge il_in_clk or negedge il_in_rst) begin
    if (!il_in_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign il_out_ready    = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                           (state_q == DATA)   || (state_q == CHECK);
  assign il_out_busy     = il_out_ready || (state_q == WRITE);
  assign il_out_wren     = (state_q == WRITE);
  assign il_out_addr     = addr_q;
  assign il_out_data     = data_q;
  assign il_out_done     = (state_q == DONE);
  assign il_out_error    = (state_q == ERROR);
  assign il_out_cpu_hold = il_out_busy || il_out_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
// Follows IMEM_LOADER_CHECKSUM_EN when defined for the build.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              valid = 1'b0;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              wren;
  logic              hold;
  logic              busy;
  logic              done;
  logic              error;

  int tests_run = 0;
  int tests_failed = 0;
  wr_t wr_q[$];
  int busy_not_ready = 0;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .il_in_clk       (clk),
    .il_in_rst       (rst_n),
    .il_in_start     (start),
    .il_in_byte      (din),
    .il_in_valid     (valid),
    .il_out_ready    (ready),
    .il_out_addr     (addr),
    .il_out_data     (data),
    .il_out_wren     (wren),
    .il_out_cpu_hold (hold),
    .il_out_busy     (busy),
    .il_out_done     (done),
    .il_out_error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wren) wr_q.push_back({addr, data});
      if (busy && !ready) busy_not_ready++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference frame: header, big-endian payload, then the byte sum when checksums are enabled.
  function automatic bq_t build_frame(input logic [15:0] n, input wq_t words);
    bq_t b;
    int  sum = 0;
    b.push_back(n[15:8]);
    b.push_back(n[7:0]);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
        sum = sum + int'((words[i] >> (8 * k)) & 32'hFF);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'(sum % 256));
`endif
    return b;
  endfunction

  // Called at a negedge; returns at a negedge once every byte has been accepted.
  task automatic run_frame(input string tag, input bq_t b, input int gap_pct);
    int idx = 0;
    int budget = b.size() * 40 + 50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < b.size() && budget > 0) begin
      valid = ($urandom_range(99) >= gap_pct);
      din   = valid ? b[idx] : 8'($urandom_range(255));
      if (valid && ready) idx++;
      @(negedge clk);
      budget--;
    end
    valid = 1'b0;
    if (idx < b.size()) check({tag, " timeout"}, idx, b.size());
    repeat (4) @(negedge clk);
    $display("[TB] frame %s: %0d/%0d bytes sent, %0d writes", tag, idx, b.size(), wr_q.size());
  endtask

  task automatic expect_ok(input string tag, input wq_t words);
    check({tag, " wcount"}, wr_q.size(), words.size());
    foreach (words[i]) begin
      if (i < wr_q.size()) begin
        check($sformatf("%s addr%0d", tag, i), 32'(wr_q[i].addr), 32'(i % (1 << ADDR_W)));
        check($sformatf("%s data%0d", tag, i), wr_q[i].data, words[i]);
      end
    end
    check({tag, " done"}, done, 1);
    check({tag, " error"}, error, 0);
    check({tag, " hold"}, hold, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic expect_bad_header(input string tag, input logic [15:0] n);
    bq_t b;
    b.push_back(n[15:8]);
    b.push_back(n[7:0]);
    wr_q.delete();
    run_frame(tag, b, 0);
    check({tag, " error"}, error, 1);
    check({tag, " done"}, done, 0);
    check({tag, " wcount"}, wr_q.size(), 0);
    check({tag, " hold"}, hold, 1);
    check({tag, " ready"}, ready, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"}, ready, 0);
    check({tag, " wren"}, wren, 0);
    check({tag, " hold"}, hold, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " addr"}, 32'(addr), 0);
    check({tag, " data"}, data, 0);
  endtask

  initial begin
    wq_t w;
    bq_t b;
    bq_t part;
    int  nr0;

    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Two words at full rate
    w = '{32'h20080005, 32'h00000000};
    wr_q.delete();
    run_frame("n2", build_frame(16'd2, w), 0);
    expect_ok("n2", w);

    expect_bad_header("hdr0", 16'h0000);
    expect_bad_header("hdr1025", 16'h0401);

    // Randomly gapped valid; only WRITE cycles may drop ready while busy
    w = '{};
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    wr_q.delete();
    nr0 = busy_not_ready;
    run_frame("n3_gap", build_frame(16'd3, w), 40);
    expect_ok("n3_gap", w);
    check("n3_gap ready_low_cycles", busy_not_ready - nr0, 3);

    // Reset asserted while the 6th payload byte is offered
    w = '{$urandom, $urandom};
    b = build_frame(16'd2, w);
    part = '{};
    for (int i = 0; i < 7; i++) part.push_back(b[i]);
    wr_q.delete();
    run_frame("partial", part, 0);
    check("partial wcount", wr_q.size(), 1);
    valid = 1'b1;
    din   = b[7];
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (3) @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_abort");
    check("after_abort wcount", wr_q.size(), 1);
    w = '{$urandom};
    wr_q.delete();
    run_frame("n1_clean", build_frame(16'd1, w), 0);
    expect_ok("n1_clean", w);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h01020304};
    wr_q.delete();
    run_frame("csum_ok", '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 0);
    expect_ok("csum_ok", w);
    wr_q.delete();
    run_frame("csum_bad", '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B}, 0);
    check("csum_bad error", error, 1);
    check("csum_bad done", done, 0);
    check("csum_bad hold", hold, 1);
    check("csum_bad wcount", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check("csum_bad addr", 32'(wr_q[0].addr), 0);
      check("csum_bad data", wr_q[0].data, 32'h01020304);
    end
`endif

    // Full-depth frame
    w = '{};
    for (int i = 0; i < DEPTH; i++) w.push_back(32'hA5000000 + 32'(i));
    wr_q.delete();
    run_frame("n1024", build_frame(16'(DEPTH), w), 0);
    expect_ok("n1024", w);
    if (wr_q.size() > 0) check("n1024 last_addr", 32'(wr_q[wr_q.size() - 1].addr), DEPTH - 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
